adc_spi_capture: RTL and testbench
==================================

ADC_SPI_CAPTURE -- requirements
Module: adc_spi_capture

Interface
REQ-001 Parameter HALF_PERIOD, default 25: system clocks per SCK half-period (1 MHz SCK at 50 MHz); legal range 2..255.
REQ-002 clock  input  1  system clock (50 MHz); all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 sample_tick  input  1  one-cycle strobe from the 1 kHz divider; requests one conversion.
REQ-005 channel  input  1  ADC channel select, captured on the accepted tick.
REQ-006 adc_sdo  input  1  serial data from the ADC.
REQ-007 adc_cs_n  output  1  ADC chip select, active low.
REQ-008 adc_sck  output  1  SPI clock, idle low (mode 0,0).
REQ-009 adc_sdi  output  1  serial command to the ADC.
REQ-010 data_out  output  10  last completed conversion result.
REQ-011 data_valid  output  1  one-cycle pulse when data_out updates.
REQ-012 busy  output  1  high from the cycle after an accepted tick until return to IDLE.
REQ-013 overrun  output  1  sticky flag: a tick arrived while busy.

Function
REQ-014 FSM states: IDLE, SETUP, SHIFT, HOLD; a half-period counter runs 0..HALF_PERIOD-1 in every non-IDLE state.
REQ-015 IDLE: adc_cs_n=1, adc_sck=0, adc_sdi=0; on sample_tick, latch channel, load 16-bit command {1,1,channel,1,12'b0} and enter SETUP next cycle.
REQ-016 SETUP (HALF_PERIOD cycles): adc_cs_n=0, adc_sck=0, adc_sdi=command bit 15; then enter SHIFT.
REQ-017 SHIFT: exactly 16 SCK periods, each HALF_PERIOD cycles high then HALF_PERIOD cycles low.
REQ-018 adc_sdo is sampled in the same clock cycle that adc_sck is driven from 0 to 1; samples from SCK periods 7..16 (the final 10) shift MSB-first into the result register, earlier samples are discarded.
REQ-019 adc_sdi advances to the next command bit in the cycle adc_sck is driven from 1 to 0; after bit 0 it holds 0.
REQ-020 After the 16th low phase: adc_cs_n=1, data_out takes the shifted result, data_valid=1 for exactly that one cycle, state HOLD.
REQ-021 HOLD (HALF_PERIOD cycles, CS-high minimum): adc_cs_n=1, adc_sck=0; then IDLE.
REQ-022 Total accepted-tick to IDLE = 34*HALF_PERIOD+1 cycles (851 at default); data_valid occurs 33*HALF_PERIOD+1 cycles after the tick.
REQ-023 sample_tick while busy (SETUP/SHIFT/HOLD) is ignored, does not restart the frame, and sets overrun.
REQ-024 sample_tick coincident with the final HOLD cycle is ignored and sets overrun; a tick in IDLE is always accepted.
REQ-025 channel changes during a frame do not affect the frame in progress.
REQ-026 data_out holds its value between conversions; never changes mid-frame.

Reset
REQ-027 reset has priority over all inputs, including sample_tick in the same cycle.
REQ-028 On reset: state IDLE, adc_cs_n=1, adc_sck=0, adc_sdi=0, data_out=0, data_valid=0, busy=0, overrun=0, counters 0.
REQ-029 reset mid-frame aborts the frame within one cycle (CS deasserted) with no data_valid pulse; next tick starts a full fresh frame.

Structure
REQ-030 Shared package adc_pkg holds the state encoding, FRAME_BITS=16, DATA_BITS=10, and the command-header constant.
REQ-031 One sub-module, sck_halfper_counter, generates the half-period terminal-count strobe; all SPI sequencing stays in adc_spi_capture.

Verification
REQ-032 Reset then idle 1000 cycles -> adc_cs_n=1, adc_sck=0, data_out=0, no data_valid, busy=0.
REQ-033 Tick, channel=1, ADC model returns 0x2A5 -> adc_sdi stream 1,1,1,1 then zeros; 16 SCK rising edges; data_out=0x2A5, data_valid one cycle at tick+826.
REQ-034 Ticks every 50000 cycles, model returns 0x000 then 0x3FF then 0x155 -> three matching data_valid pulses, overrun=0.
REQ-035 Second tick 100 cycles after first -> single frame only, overrun=1 until reset, result unaffected.
REQ-036 Reset asserted at SCK period 8 -> adc_cs_n=1 next cycle, no data_valid, subsequent tick yields correct full frame.
REQ-037 HALF_PERIOD=2 with tick on final HOLD cycle -> tick ignored, overrun=1; tick one cycle later accepted.

Source files
------------

// File: rtl/adc_spi_capture_pkg.sv
// Shared types and constants for the ADC SPI capture block.
// Holds the FSM encoding, frame sizes and the ADC command header.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } state_t;

  localparam int FRAME_BITS = 16;
  localparam int DATA_BITS  = 10;

  // start, single-ended, channel slot (0), MSB-first, 12 don't-care
  localparam logic [FRAME_BITS-1:0] CMD_HDR = 16'hD000;

  function automatic logic [FRAME_BITS-1:0] make_cmd(logic ch);
    logic [FRAME_BITS-1:0] c;
    c = CMD_HDR;
    c[13] = ch;
    return c;
  endfunction

endpackage

// File: rtl/adc_spi_capture_if.sv
// SPI bus between the capture controller and the ADC.
// master: drives adc_cs_n/adc_sck/adc_sdi, reads adc_sdo; slave: reverse.
interface adc_spi_capture_if;
  logic adc_cs_n;
  logic adc_sck;
  logic adc_sdi;
  logic adc_sdo;

  modport master (
    output adc_cs_n,
    output adc_sck,
    output adc_sdi,
    input  adc_sdo
  );

  modport slave (
    input  adc_cs_n,
    input  adc_sck,
    input  adc_sdi,
    output adc_sdo
  );
endinterface

// File: rtl/adc_spi_capture_counter.sv
// Half-period counter: counts 0..HALF_PERIOD-1 while run is high.
// Ports: clock, reset, run in; tc = terminal-count strobe out.
module sck_halfper_counter #(
  parameter int HALF_PERIOD = 25
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  output logic tc
);

  logic [7:0] cnt;

  assign tc = run && (cnt == 8'(HALF_PERIOD - 1));

  always_ff @(posedge clock) begin
    if (reset || !run) begin
      cnt <= '0;
    end else if (tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/adc_spi_capture.sv
// Captures one 10-bit ADC conversion over SPI (mode 0) per sample_tick.
// Ports: clock, reset, sample_tick, channel, spi bus, data_out/valid, busy, overrun.
module adc_spi_capture
  import adc_pkg::*;
#(
  parameter int HALF_PERIOD = 25
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 channel,
  adc_spi_capture_if.master    spi,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 busy,
  output logic                 overrun
);

  state_t                  state;
  logic                    tc;
  logic                    run;
  logic [FRAME_BITS-1:0]   cmd;
  logic [DATA_BITS-1:0]    shreg;
  logic [3:0]              period;

  assign run = (state != IDLE);

  sck_halfper_counter #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_cnt (
    .clock(clock),
    .reset(reset),
    .run  (run),
    .tc   (tc)
  );

  // Samples are shifted in on every rising SCK; the 10-bit register
  // keeps only the last ten, so the six leading ones fall out.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      spi.adc_cs_n <= 1'b1;
      spi.adc_sck  <= 1'b0;
      spi.adc_sdi  <= 1'b0;
      cmd          <= '0;
      shreg        <= '0;
      period       <= '0;
      data_out     <= '0;
      data_valid   <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (sample_tick && state != IDLE) begin
        overrun <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (sample_tick) begin
            cmd          <= make_cmd(channel);
            spi.adc_cs_n <= 1'b0;
            spi.adc_sdi  <= CMD_HDR[FRAME_BITS-1];
            period       <= '0;
            busy         <= 1'b1;
            state        <= SETUP;
          end
        end
        SETUP: begin
          if (tc) begin
            spi.adc_sck <= 1'b1;
            shreg       <= {shreg[DATA_BITS-2:0], spi.adc_sdo};
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          if (tc) begin
            if (spi.adc_sck) begin
              spi.adc_sck <= 1'b0;
              spi.adc_sdi <= cmd[FRAME_BITS-2];
              cmd         <= cmd << 1;
            end else if (period == 4'(FRAME_BITS - 1)) begin
              spi.adc_cs_n <= 1'b1;
              spi.adc_sdi  <= 1'b0;
              data_out     <= shreg;
              data_valid   <= 1'b1;
              state        <= HOLD;
            end else begin
              spi.adc_sck <= 1'b1;
              period      <= period + 4'd1;
              shreg       <= {shreg[DATA_BITS-2:0], spi.adc_sdo};
            end
          end
        end
        HOLD: begin
          if (tc) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_capture.sv
// Scoreboard bench for adc_spi_capture with a behavioural SPI ADC model.
// A second instance at HALF_PERIOD=2 exercises the final-HOLD tick window.
module tb_adc_spi_capture;

  localparam int DV_LAT = 826;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       sample_tick = 1'b0;
  logic       channel = 1'b0;
  logic       tick2 = 1'b0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  always #10 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  adc_spi_capture_if spi1 ();
  adc_spi_capture_if spi2 ();

  logic [9:0] data_out, data_out2;
  logic       data_valid, busy, overrun;
  logic       dv2, busy2, ovr2;

  adc_spi_capture #(.HALF_PERIOD(25)) dut (
    .clock      (clock),
    .reset      (reset),
    .sample_tick(sample_tick),
    .channel    (channel),
    .spi        (spi1),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  adc_spi_capture #(.HALF_PERIOD(2)) dut2 (
    .clock      (clock),
    .reset      (reset),
    .sample_tick(tick2),
    .channel    (1'b0),
    .spi        (spi2),
    .data_out   (data_out2),
    .data_valid (dv2),
    .busy       (busy2),
    .overrun    (ovr2)
  );

  assign spi2.adc_sdo = 1'b0;

  // ADC model: sdo presents the bit for the next SCK period; periods
  // 7..16 carry the 10-bit value MSB-first, earlier periods read 0.
  logic [9:0]  adc_val = '0;
  logic [15:0] adc_word;
  logic [4:0]  rc = '0;
  logic [15:0] sdi_cap = '0;

  assign adc_word = {6'b0, adc_val};
  assign spi1.adc_sdo = rc[4] ? 1'b0 : adc_word[~rc[3:0]];

  always @(posedge spi1.adc_sck or negedge spi1.adc_cs_n) begin
    if (!spi1.adc_sck) begin
      rc      <= '0;
      sdi_cap <= '0;
    end else begin
      rc      <= rc + 5'd1;
      sdi_cap <= {sdi_cap[14:0], spi1.adc_sdi};
    end
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  typedef struct {
    logic [9:0] d;
    int         c;
  } exp_t;

  exp_t       q[$];
  logic [9:0] prev_out = '0;

  always @(negedge clock) begin
    exp_t e;
    if (data_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got pulse data_out=%0h, required none (cycle %0d)",
                 data_out, cyc);
      end else begin
        e = q.pop_front();
        chk("data_out", 32'(data_out), 32'(e.d));
        chk("valid_cycle", 32'(cyc), 32'(e.c));
      end
    end
    if (busy && !data_valid) chk("data_hold", 32'(data_out), 32'(prev_out));
    prev_out = data_out;
  end

  task automatic frame(input logic ch, input logic [9:0] v, input logic expect_dv);
    adc_val     = v;
    channel     = ch;
    sample_tick = 1'b1;
    if (expect_dv) q.push_back('{v, cyc + DV_LAT});
    @(negedge clock);
    sample_tick = 1'b0;
    channel     = ~ch;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000; i++) begin
      if (q.size() == 0) break;
      @(negedge clock);
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending, required 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    int bad;
    repeat (3) @(negedge clock);
    sample_tick = 1'b1;
    @(negedge clock);
    sample_tick = 1'b0;
    chk("rst_tick_busy", 32'(busy), 0);
    chk("rst_tick_cs", 32'(spi1.adc_cs_n), 1);
    reset = 1'b0;
    chk("rst_sck", 32'(spi1.adc_sck), 0);
    chk("rst_sdi", 32'(spi1.adc_sdi), 0);
    chk("rst_data", 32'(data_out), 0);
    chk("rst_valid", 32'(data_valid), 0);
    chk("rst_overrun", 32'(overrun), 0);

    bad = 0;
    repeat (1000) begin
      @(negedge clock);
      if (!spi1.adc_cs_n || spi1.adc_sck || busy) bad++;
    end
    chk("idle_quiet", 32'(bad), 0);
    chk("idle_data", 32'(data_out), 0);

    // HALF_PERIOD=2: frame ends (IDLE) at tick+69, final HOLD at tick+68
    tick2 = 1'b1;
    @(negedge clock);
    tick2 = 1'b0;
    repeat (66) @(negedge clock);
    chk("hp2_busy_hold", 32'(busy2), 1);
    chk("hp2_ovr_pre", 32'(ovr2), 0);
    @(negedge clock);
    tick2 = 1'b1;
    @(negedge clock);
    chk("hp2_idle", 32'(busy2), 0);
    chk("hp2_ovr_set", 32'(ovr2), 1);
    @(negedge clock);
    tick2 = 1'b0;
    chk("hp2_accept", 32'(busy2), 1);
    chk("hp2_cs", 32'(spi2.adc_cs_n), 0);

    frame(1'b1, 10'h2A5, 1'b1);
    chk("f1_busy", 32'(busy), 1);
    wait_drain();
    chk("f1_sdi", 32'(sdi_cap), 32'h0000_F000);
    chk("f1_rises", 32'(rc), 16);
    repeat (200) @(negedge clock);
    chk("f1_idle", 32'(busy), 0);

    frame(1'b0, 10'h000, 1'b1);
    wait_drain();
    chk("f2_sdi", 32'(sdi_cap), 32'h0000_D000);
    repeat (200) @(negedge clock);
    frame(1'b0, 10'h3FF, 1'b1);
    wait_drain();
    repeat (200) @(negedge clock);
    frame(1'b1, 10'h155, 1'b1);
    wait_drain();
    chk("f4_sdi", 32'(sdi_cap), 32'h0000_F000);
    repeat (200) @(negedge clock);
    chk("seq_overrun", 32'(overrun), 0);

    frame(1'b0, 10'h0C3, 1'b1);
    repeat (99) @(negedge clock);
    sample_tick = 1'b1;
    @(negedge clock);
    sample_tick = 1'b0;
    chk("ovr_set", 32'(overrun), 1);
    wait_drain();
    repeat (1000) @(negedge clock);
    chk("ovr_sticky", 32'(overrun), 1);
    chk("ovr_result", 32'(data_out), 32'h0C3);

    frame(1'b0, 10'h3C3, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      if (rc == 5'd8) break;
      @(negedge clock);
    end
    chk("abort_reach_p8", 32'(rc), 8);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_cs", 32'(spi1.adc_cs_n), 1);
    chk("abort_sck", 32'(spi1.adc_sck), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_ovr", 32'(overrun), 0);
    repeat (1000) @(negedge clock);
    chk("abort_data", 32'(data_out), 0);
    frame(1'b0, 10'h1E7, 1'b1);
    wait_drain();
    chk("fresh_sdi", 32'(sdi_cap), 32'h0000_D000);
    chk("fresh_rises", 32'(rc), 16);
    repeat (100) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
